// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter: round-robin share of one ripple adder/subtractor between
// NUM_REQ requesters, result held in a one-entry valid/ready response register.
// Build option: define ADDER_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_overflow,
  output logic                     rsp_zero
);

  localparam int CW = IDW + 1;

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
  logic             rsp_ovf_q,   rsp_ovf_d;
  logic             rsp_zero_q,  rsp_zero_d;

  logic             w_can_accept;
  logic             w_grant_any;
  logic             w_grant;
  logic [IDW-1:0]   w_grant_idx;

  logic [WIDTH-1:0] w_a, w_b, w_b_eff, w_sum;
  logic             w_sub, w_cout, w_ovf;

  assign w_can_accept = ~rsp_valid_q | rsp_ready;
  assign w_grant      = w_grant_any & w_can_accept & ~rst;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_grant_any = 1'b1;
        w_grant_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] last_grant_q;
  logic [CW-1:0]  w_cand;

  // Search starts one past the last winner; one subtraction suffices for wrap.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, last_grant_q} + CW'(i + 1);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!w_grant_any && req_valid[w_cand[IDW-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else if (w_grant) begin
      last_grant_q <= w_grant_idx;
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_a     = req_a[w_grant_idx*WIDTH +: WIDTH];
  assign w_b     = req_b[w_grant_idx*WIDTH +: WIDTH];
  assign w_sub   = req_sub[w_grant_idx];
  assign w_b_eff = w_b ^ {WIDTH{w_sub}};

  // Ripple chain; subtraction is a + ~b with carry-in of 1.
  always_comb begin
    logic c;
    c     = w_sub;
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = w_a[i] ^ w_b_eff[i] ^ c;
      c        = (w_a[i] & w_b_eff[i]) | (c & (w_a[i] ^ w_b_eff[i]));
    end
    w_cout = c;
  end

  assign w_ovf = w_sub ? ((~w_a[WIDTH-1] &  w_b[WIDTH-1] &  w_sum[WIDTH-1]) |
                          ( w_a[WIDTH-1] & ~w_b[WIDTH-1] & ~w_sum[WIDTH-1]))
                       : w_cout;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_zero_d  = rsp_zero_q;
    if (w_grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = w_grant_idx;
      rsp_sum_d   = w_sum;
      rsp_ovf_d   = w_ovf;
      rsp_zero_d  = (w_sum == '0);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_zero     = rsp_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter: directed vectors for adder_arbiter with a scoreboard queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_adder_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_overflow;
  logic           rsp_zero;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
    req_sub[k]      = s;
  endtask

  task automatic push(input int k, input logic [31:0] s, input logic o, input logic z);
    sb.push_back('{id: 2'(k), sum: s, ovf: o, zero: z});
  endtask

  // Present one request, wait (bounded) for its grant, then check 1-cycle latency.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] es, input logic eo, input logic ez);
    bit got = 1'b0;
    set_op(k, a, b, s);
    req_valid[k] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: requester %0d got no grant, required within 20 cycles", k);
    end else begin
      push(k, es, eo, ez);
    end
    tick();
    req_valid[k] = 1'b0;
    if (got) begin
      @(negedge clk);
      chk("latency_valid", 32'(rsp_valid), 32'd1);
      chk("latency_id", 32'(rsp_id), 32'(k));
    end
    tick();
  endtask

  // Monitor: every response handshake pops and checks the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d sum 0x%08h, required no response", rsp_id, rsp_sum);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_sum", rsp_sum, e.sum);
          chk("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    for (int k = 0; k < N; k++) set_op(k, 32'(k), 32'd1, 1'b0);
    req_valid = '1;

    // Reset held with all requesters valid
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_rsp_overflow", 32'(rsp_overflow), 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    tick();
    rst = 1'b0;

    // Round-robin order 0,1,2,3,0; requester k computes k+1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_order", 32'(req_ready), 32'(4'b0001 << (i % N)));
      push(i % N, 32'((i % N) + 1), 1'b0, 1'b0);
    end
    tick();
    req_valid = '0;
    tick();

    issue(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    issue(3, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    issue(0, 32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    issue(0, 32'd5,         32'd5,         1'b1, 32'h0000_0000, 1'b0, 1'b1);

    // Backpressure with requesters 1 and 3 valid
    rsp_ready = 1'b0;
    set_op(1, 32'd10, 32'd3, 1'b0);
    set_op(3, 32'd3, 32'd10, 1'b1);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("bp_first_grant", 32'(req_ready), 32'b0010);
    push(1, 32'd13, 1'b0, 1'b0);
    tick();
    req_valid[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_sum", rsp_sum, 32'd13);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_regrant", 32'(req_ready), 32'b1000);
    push(3, 32'hFFFF_FFF9, 1'b0, 1'b0);
    tick();
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("bp_valid_held", 32'(rsp_valid), 32'd1);
    tick();

    // Reset while a result is pending under backpressure
    rsp_ready = 1'b0;
    set_op(2, 32'd1, 32'd2, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("mid_pending_valid", 32'(rsp_valid), 32'd1);
    chk("mid_pending_sum", rsp_sum, 32'd3);
    tick();
    rst = 1'b1;
    for (int k = 0; k < N; k++) set_op(k, 32'(k), 32'd1, 1'b0);
    req_valid = '1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("mid_restart", 32'(req_ready), 32'b0001);
    push(0, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_next", 32'(req_ready), 32'b0010);
    push(1, 32'd2, 1'b0, 1'b0);
    tick();
    req_valid = '0;
    repeat (3) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
